// File: rtl/full_adder_unit_if.sv
// full_adder_unit_if: operand/result bundle for full_adder_unit.
// The master drives the operands and in_valid. The slave (the adder) drives
// the registered result and its flags.
interface full_adder_unit_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;
  logic             Zero;

  modport master (
    output in_valid, A, B, Cin,
    input  out_valid, Sum, Cout, Ovf, Zero
  );

  modport slave (
    input  in_valid, A, B, Cin,
    output out_valid, Sum, Cout, Ovf, Zero
  );
endinterface

// File: rtl/full_adder_unit.sv
// full_adder_unit: registered ripple-carry adder, Sum = A + B + Cin.
// It also produces the carry-out, signed overflow and zero flags.
// When in_valid is low, the result registers keep their previous contents.
// Optional macro FULL_ADDER_PIPE2_EN adds a second register stage:
//   - stage 1 ripples the lower ceil(WIDTH/2) bits;
//   - stage 2 finishes the upper half and the flags.
// With the macro defined, latency is 2 cycles; otherwise it is 1 cycle.
module full_adder_unit #(
  parameter int WIDTH = 1
) (
  input  logic              clk,
  input  logic              rst,
  full_adder_unit_if.slave  bus
);

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic             zero_d, zero_q;

`ifdef FULL_ADDER_PIPE2_EN
  localparam int LO = (WIDTH + 1) / 2;
  localparam int HI = WIDTH - LO;
  localparam int HW = (HI > 0) ? HI : 1;

  logic          s1_valid_d, s1_valid_q;
  logic [LO-1:0] s1_lo_d, s1_lo_q;
  logic          s1_mid_d, s1_mid_q;
  logic          s1_cpre_d, s1_cpre_q;
  logic [HW-1:0] s1_a_hi_d, s1_a_hi_q;
  logic [HW-1:0] s1_b_hi_d, s1_b_hi_q;
  logic          s1_c;
  logic [WIDTH-1:0] s2_sum;
  logic          s2_c;
  logic          s2_cmsb;

  // Stage 1: ripple the low half and capture the mid carry.
  // It also captures the carry into the top low bit, which becomes the
  // MSB carry-in when WIDTH=1. The upper operand halves are forwarded.
  always_comb begin
    s1_valid_d = bus.in_valid;
    s1_lo_d    = s1_lo_q;
    s1_mid_d   = s1_mid_q;
    s1_cpre_d  = s1_cpre_q;
    s1_a_hi_d  = s1_a_hi_q;
    s1_b_hi_d  = s1_b_hi_q;
    s1_c       = bus.Cin;
    if (bus.in_valid) begin
      s1_cpre_d = bus.Cin;
      s1_a_hi_d = '0;
      s1_b_hi_d = '0;
      for (int i = 0; i < LO; i++) begin
        s1_cpre_d  = s1_c;
        s1_lo_d[i] = bus.A[i] ^ bus.B[i] ^ s1_c;
        s1_c       = (bus.A[i] & bus.B[i]) | (s1_c & (bus.A[i] ^ bus.B[i]));
      end
      s1_mid_d = s1_c;
      for (int i = LO; i < WIDTH; i++) begin
        s1_a_hi_d[i-LO] = bus.A[i];
        s1_b_hi_d[i-LO] = bus.B[i];
      end
    end
  end

  // Stage 1 register; reset drops any operand pair that is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= '0;
      s1_mid_q   <= 1'b0;
      s1_cpre_q  <= 1'b0;
      s1_a_hi_q  <= '0;
      s1_b_hi_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_lo_q    <= s1_lo_d;
      s1_mid_q   <= s1_mid_d;
      s1_cpre_q  <= s1_cpre_d;
      s1_a_hi_q  <= s1_a_hi_d;
      s1_b_hi_q  <= s1_b_hi_d;
    end
  end

  // Stage 2: continue the ripple from the mid carry and compute the flags.
  // With WIDTH=1 the upper loop is empty, so this stage only delays stage 1.
  always_comb begin
    out_valid_d = s1_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    s2_c        = s1_mid_q;
    s2_cmsb     = s1_cpre_q;
    s2_sum      = '0;
    for (int i = 0; i < LO; i++) begin
      s2_sum[i] = s1_lo_q[i];
    end
    for (int i = LO; i < WIDTH; i++) begin
      s2_cmsb   = s2_c;
      s2_sum[i] = s1_a_hi_q[i-LO] ^ s1_b_hi_q[i-LO] ^ s2_c;
      s2_c      = (s1_a_hi_q[i-LO] & s1_b_hi_q[i-LO]) |
                  (s2_c & (s1_a_hi_q[i-LO] ^ s1_b_hi_q[i-LO]));
    end
    if (s1_valid_q) begin
      sum_d  = s2_sum;
      cout_d = s2_c;
      ovf_d  = s2_c ^ s2_cmsb;
      zero_d = (s2_sum == '0);
    end
  end
`else
  logic [WIDTH-1:0] rip_sum;
  logic             rip_c;
  logic             rip_cmsb;

  // Single-stage ripple from Cin.
  // Track the carry into the MSB so the signed-overflow flag can be formed.
  always_comb begin
    out_valid_d = bus.in_valid;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    rip_sum     = '0;
    rip_c       = bus.Cin;
    rip_cmsb    = bus.Cin;
    for (int i = 0; i < WIDTH; i++) begin
      rip_cmsb   = rip_c;
      rip_sum[i] = bus.A[i] ^ bus.B[i] ^ rip_c;
      rip_c      = (bus.A[i] & bus.B[i]) | (rip_c & (bus.A[i] ^ bus.B[i]));
    end
    if (bus.in_valid) begin
      sum_d  = rip_sum;
      cout_d = rip_c;
      ovf_d  = rip_c ^ rip_cmsb;
      zero_d = (rip_sum == '0);
    end
  end
`endif

  // Result register. Reset forces a clean, invalid, all-zero result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.Sum       = sum_q;
  assign bus.Cout      = cout_q;
  assign bus.Ovf       = ovf_q;
  assign bus.Zero      = zero_q;

endmodule

// File: tb/tb_full_adder_unit.sv
// tb_full_adder_unit: directed bench for full_adder_unit.
// It drives a WIDTH=1 instance and a WIDTH=8 instance.
// Expected results are queued and compared LAT cycles after each input.
// LAT is 2 when FULL_ADDER_PIPE2_EN is defined, otherwise 1.
module tb_full_adder_unit;

`ifdef FULL_ADDER_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    string      tag;
    logic       v;
    logic [7:0] s;
    logic       c;
    logic       o;
    logic       z;
  } exp_t;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;
  exp_t q1[$];
  exp_t q8[$];
  logic [3:0] sweepExp [8];

  full_adder_unit_if #(.WIDTH(1)) if1 ();
  full_adder_unit_if #(.WIDTH(8)) if8 ();

  full_adder_unit #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  full_adder_unit #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    testsRun++;
    assert (obs === expv) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkEntry1(input exp_t e);
    checkOutput({e.tag, ".valid"}, 64'(if1.out_valid), 64'(e.v));
    checkOutput({e.tag, ".sum"},   64'(if1.Sum),       64'(e.s[0]));
    checkOutput({e.tag, ".cout"},  64'(if1.Cout),      64'(e.c));
    checkOutput({e.tag, ".ovf"},   64'(if1.Ovf),       64'(e.o));
    checkOutput({e.tag, ".zero"},  64'(if1.Zero),      64'(e.z));
  endtask

  task automatic checkEntry8(input exp_t e);
    checkOutput({e.tag, ".valid"}, 64'(if8.out_valid), 64'(e.v));
    checkOutput({e.tag, ".sum"},   64'(if8.Sum),       64'(e.s));
    checkOutput({e.tag, ".cout"},  64'(if8.Cout),      64'(e.c));
    checkOutput({e.tag, ".ovf"},   64'(if8.Ovf),       64'(e.o));
    checkOutput({e.tag, ".zero"},  64'(if8.Zero),      64'(e.z));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus1(input string tag, input logic v, input logic a, input logic b,
                                input logic cin, input logic ev, input logic es, input logic ec,
                                input logic eo, input logic ez);
    exp_t e;
    if1.in_valid = v; if1.A = a; if1.B = b; if1.Cin = cin;
    if8.in_valid = 1'b0;
    e = '{tag, ev, {7'b0, es}, ec, eo, ez};
    q1.push_back(e);
    tick();
    if (q1.size() >= LAT) checkEntry1(q1.pop_front());
  endtask

  task automatic applyStimulus8(input string tag, input logic v, input logic [7:0] a,
                                input logic [7:0] b, input logic cin, input logic ev,
                                input logic [7:0] es, input logic ec, input logic eo, input logic ez);
    exp_t e;
    if8.in_valid = v; if8.A = a; if8.B = b; if8.Cin = cin;
    if1.in_valid = 1'b0;
    e = '{tag, ev, es, ec, eo, ez};
    q8.push_back(e);
    tick();
    if (q8.size() >= LAT) checkEntry8(q8.pop_front());
  endtask

  // Directed sequence
  initial begin
    exp_t zeroE;
    testsRun    = 0;
    testsFailed = 0;
    sweepExp[0] = 4'b0001; sweepExp[1] = 4'b1010; sweepExp[2] = 4'b1000; sweepExp[3] = 4'b0101;
    sweepExp[4] = 4'b1000; sweepExp[5] = 4'b0101; sweepExp[6] = 4'b0111; sweepExp[7] = 4'b1100;
    zeroE = '{"reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    if1.in_valid = 1'b1; if1.A = 1'b1; if1.B = 1'b1; if1.Cin = 1'b1;
    if8.in_valid = 1'b1; if8.A = 8'hFF; if8.B = 8'h01; if8.Cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    if1.in_valid = 1'b0;
    if8.in_valid = 1'b0;
    checkEntry1(zeroE);
    checkEntry8(zeroE);

    // WIDTH=1: four-vector stream; S C O Z
    applyStimulus1("w1_000", 1, 0, 0, 0, 1, 0, 0, 0, 1);
    applyStimulus1("w1_001", 1, 0, 0, 1, 1, 1, 0, 1, 0);
    applyStimulus1("w1_010", 1, 0, 1, 0, 1, 1, 0, 0, 0);
    applyStimulus1("w1_111", 1, 1, 1, 1, 1, 1, 1, 0, 0);

    // WIDTH=1: exhaustive sweep with index bits {A,B,Cin}
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      logic [3:0] ex;
      idx = 3'(i);
      ex  = sweepExp[i];
      applyStimulus1($sformatf("w1_sweep%0d", i), 1, idx[2], idx[1], idx[0],
                     1, ex[3], ex[2], ex[1], ex[0]);
    end
    applyStimulus1("w1_idle_hold", 0, 0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus1("w1_idle_hold2", 0, 0, 0, 0, 0, 1, 1, 0, 0);

    // WIDTH=8 boundary cases
    applyStimulus8("w8_ff_01_0", 1, 8'hFF, 8'h01, 0, 1, 8'h00, 1, 0, 1);
    applyStimulus8("w8_7f_00_1", 1, 8'h7F, 8'h00, 1, 1, 8'h80, 0, 1, 0);
    applyStimulus8("w8_ff_ff_1", 1, 8'hFF, 8'hFF, 1, 1, 8'hFF, 1, 0, 0);
    applyStimulus8("w8_80_80_0", 1, 8'h80, 8'h80, 0, 1, 8'h00, 1, 1, 1);
    applyStimulus8("w8_12_34_0", 1, 8'h12, 8'h34, 0, 1, 8'h46, 0, 0, 0);

    // Valid gap: results hold while out_valid drops
    applyStimulus8("gap_idle",   0, 8'hAA, 8'h55, 1, 0, 8'h46, 0, 0, 0);
    applyStimulus8("gap_01_01",  1, 8'h01, 8'h01, 1, 1, 8'h03, 0, 0, 0);
    applyStimulus8("gap_tail",   0, 8'h00, 8'h00, 0, 0, 8'h03, 0, 0, 0);
    applyStimulus8("gap_tail2",  0, 8'h00, 8'h00, 0, 0, 8'h03, 0, 0, 0);

    // Reset with a result in flight; reset overrides in_valid
    if8.in_valid = 1'b1; if8.A = 8'h55; if8.B = 8'h0A; if8.Cin = 1'b0;
    tick();
    rst = 1'b1;
    if8.A = 8'hFF; if8.B = 8'hFF; if8.Cin = 1'b1;
    tick();
    q1.delete();
    q8.delete();
    zeroE.tag = "rst_flight";
    checkEntry8(zeroE);
    rst = 1'b0;
    if8.in_valid = 1'b0;
    tick();
    zeroE.tag = "rst_flight_after";
    checkEntry8(zeroE);
    tick();
    zeroE.tag = "rst_flight_after2";
    checkEntry8(zeroE);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/full_adder_unit.md
Name: full_adder_unit

Overview:
- Registered, width-parameterised ripple full adder: Sum = A + B + Cin, carry-out on Cout.
- Used as the arithmetic leaf in datapaths; WIDTH=1 gives the classic single-bit full adder with registered outputs.
- Adds valid qualification, signed-overflow and zero flags, and an optional second pipeline stage.

Parameters:
- WIDTH, 1, operand/sum width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  A/B/Cin are valid this cycle.
- A  input  WIDTH  operand A, unsigned/two's-complement agnostic.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in into bit 0.
- out_valid  output  1  Sum/Cout/flags hold a result.
- Sum  output  WIDTH  low WIDTH bits of A+B+Cin.
- Cout  output  1  carry out of bit WIDTH-1.
- Ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- Zero  output  1  Sum == 0.

Behaviour:
- Interface: one clock; reset is synchronous and active-high, sampled on rising clk.
- Reset: out_valid=0, Sum=0, Cout=0, Ovf=0, Zero=0 on the first rising edge with rst=1. Reset overrides in_valid in the same cycle. Reset mid-operation discards all in-flight results.
- Datapath:
  - Ripple chain of 1-bit cells.
  - s[i] = A[i]^B[i]^c[i], c[i+1] = A[i]&B[i] | c[i]&(A[i]^B[i]), c[0]=Cin.
  - Cout = c[WIDTH]; Ovf = c[WIDTH]^c[WIDTH-1]. For WIDTH=1, c[0]=Cin is used as the carry into the MSB.
- Latency:
  - 1 cycle. Inputs sampled at edge N with in_valid=1 appear on Sum/Cout/Ovf/Zero with out_valid=1 after edge N.
  - Full throughput: a new operand every cycle.
- in_valid=0 at an edge: out_valid goes 0; Sum/Cout/Ovf/Zero hold their previous values (no recompute).
- No backpressure. Results are not stalled; the consumer must take them the cycle out_valid=1.
- Wrap-around: all-ones + all-ones + 1 gives Sum = all-ones and Cout=1. Result is modulo 2^WIDTH, with the carry on Cout.
- Zero is computed from the registered Sum value, i.e. it is registered together with Sum.
- No X propagation requirement beyond reset; outputs are defined from the first reset onward.

Optional Feature:
- Macro FULL_ADDER_PIPE2_EN.
- Defined:
  - A second register stage is inserted.
  - Stage 1 registers the lower ceil(WIDTH/2) sum bits plus the mid carry, and carries the upper operand halves forward.
  - Stage 2 completes the upper half and the flags.
  - Latency is 2 cycles; throughput stays 1/cycle; out_valid is delayed accordingly.
  - Reset clears both stages' valid bits and all outputs.
  - With WIDTH=1 the split is degenerate: stage 2 is a pure delay.
- Undefined: single-stage, 1-cycle latency as above.
- Results for identical input streams are identical apart from latency.

Test Plan:
- WIDTH=1, after reset, apply (A,B,Cin) = 000, 001, 010, 111 on consecutive cycles with in_valid=1.
  -> (Sum,Cout) = (0,0), (1,0), (1,0), (1,1), one cycle later each. Zero = 1,0,0,0.
- WIDTH=1, exhaustive sweep of all 8 input combos.
  -> Sum = A^B^Cin, Cout = majority(A,B,Cin), out_valid=1 every cycle.
- WIDTH=8, A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1, Zero=1, Ovf=0.
- WIDTH=8, A=0x7F, B=0x00, Cin=1 -> Sum=0x80, Cout=0, Ovf=1. Also A=0xFF, B=0xFF, Cin=1 -> Sum=0xFF, Cout=1, Ovf=0.
- Valid gap and reset:
  - Stream valid/invalid/valid -> out_valid pattern 1,0,1 with Sum held during the gap.
  - Assert rst while a result is in flight -> next cycle out_valid=0 and all outputs 0.
- With FULL_ADDER_PIPE2_EN, rerun the WIDTH=8 cases -> identical values, each appearing 2 cycles after input.
